frame_sched: RTL and testbench

- Per-frame scheduler for the ray pipeline (ppl) and block map (map).
- On each display frame request it snapshots the player pose, pulses a pipeline start, and counts returned pixels until the frame is complete.
- Block-edit requests (player place/break) are queued in a small FIFO and committed to the map write port only between frames, so a frame never renders against a half-edited map.
- Sits between player/game logic, ppl, and map; runs in the pipeline clock domain.

---
 rtl/frame_sched_pkg.sv | 25 ++
 rtl/edit_fifo.sv | 48 ++++
 rtl/frame_sched.sv | 200 ++++++++++++++++++++
 tb/tb_frame_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sched_pkg.sv
// Shared types and widths for the frame scheduler: FSM states, pose/map field widths,
// and the pixel counter sizing helper.
package frame_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LATCH  = 2'd1,
        RENDER = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam int POS_W   = 17;
    localparam int ANG_W   = 16;
    localparam int BADDR_W = 15;
    localparam int BID_W   = 5;
    localparam int EDIT_W  = BADDR_W + BID_W;

    // Never below one bit, so a degenerate 1x1 frame still elaborates.
    function automatic int pix_cnt_w(input int h, input int v);
        int n;
        n = h * v;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edit_fifo.sv
// Synchronous FIFO holding pending block edits as {addr, data}; the pointers carry one
// extra wrap bit so full and empty are told apart without a separate counter.
module edit_fifo
    import frame_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int WIDTH      = EDIT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is left unreset; clearing the pointers is what discards the contents.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/frame_sched.sv
// Per-frame scheduler: latches the pose, starts the ray pipeline, counts pixels, and
// commits queued map edits only between frames. Optional watchdog: FRAME_SCHED_TIMEOUT_EN.
module frame_sched
    import frame_sched_pkg::*;
#(
    parameter int H_DISP      = 480,
    parameter int V_DISP      = 272,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_req,
    input  logic [POS_W-1:0]   p_pos_x,
    input  logic [POS_W-1:0]   p_pos_y,
    input  logic [POS_W-1:0]   p_pos_z,
    input  logic [ANG_W-1:0]   p_angle_x,
    input  logic [ANG_W-1:0]   p_angle_y,
    output logic [POS_W-1:0]   pose_pos_x,
    output logic [POS_W-1:0]   pose_pos_y,
    output logic [POS_W-1:0]   pose_pos_z,
    output logic [ANG_W-1:0]   pose_angle_x,
    output logic [ANG_W-1:0]   pose_angle_y,
    output logic               start,
    input  logic               px_valid,
    output logic               busy,
    input  logic               edit_valid,
    output logic               edit_ready,
    input  logic [BADDR_W-1:0] edit_addr,
    input  logic [BID_W-1:0]   edit_data,
    output logic               write_en,
    output logic [BADDR_W-1:0] write_addr,
    output logic [BID_W-1:0]   write_data,
    output logic [7:0]         frames_dropped,
    output logic               timeout
);

    localparam int             PIX_W    = pix_cnt_w(H_DISP, V_DISP);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(H_DISP * V_DISP - 1);

    state_t              state;
    state_t              state_nxt;
    logic                pending;
    logic                pending_nxt;
    logic [PIX_W-1:0]    pix_cnt;
    logic                drop;
    logic                pop;
    logic                push;
    logic                frame_done;
    logic                wd_hit;
    logic                fifo_full;
    logic                fifo_empty;
    logic [EDIT_W-1:0]   fifo_rdata;
    logic                wr_vld_p1;
    logic [BADDR_W-1:0]  wr_addr_p1;
    logic [BID_W-1:0]    wr_data_p1;

    assign push       = edit_valid && !fifo_full;
    assign edit_ready = !fifo_full;
    assign start      = (state == LATCH);
    assign busy       = (state == LATCH) || (state == RENDER);
    assign frame_done = (state == RENDER) && px_valid && (pix_cnt == PIX_LAST);
    assign write_en   = wr_vld_p1;
    assign write_addr = wr_addr_p1;
    assign write_data = wr_data_p1;

    edit_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (EDIT_W)
    ) u_edit_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({edit_addr, edit_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        drop        = 1'b0;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (frame_req)        state_nxt = LATCH;
                else if (!fifo_empty) state_nxt = COMMIT;
            end
            LATCH: begin
                state_nxt = RENDER;
                if (frame_req) begin
                    if (pending) drop = 1'b1;
                    else         pending_nxt = 1'b1;
                end
            end
            RENDER: begin
                if (frame_req) begin
                    if (pending) drop = 1'b1;
                    else         pending_nxt = 1'b1;
                end
                if (wd_hit) begin
                    state_nxt   = IDLE;
                    pending_nxt = 1'b0;
                end else if (frame_done) begin
                    state_nxt   = pending_nxt ? LATCH : IDLE;
                    pending_nxt = 1'b0;
                end
            end
            COMMIT: begin
                // Once a frame is pending no new pop starts; this cycle only lets the
                // previous write land before moving to LATCH.
                pop = !fifo_empty && !pending;
                if (frame_req) begin
                    if (pending) drop = 1'b1;
                    else         pending_nxt = 1'b1;
                end
                if (pending || fifo_empty) begin
                    state_nxt   = pending_nxt ? LATCH : IDLE;
                    pending_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pending        <= 1'b0;
            pix_cnt        <= '0;
            frames_dropped <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (state == LATCH)                  pix_cnt <= '0;
            else if (state == RENDER && px_valid) pix_cnt <= pix_cnt + PIX_W'(1);
            if (drop && frames_dropped != 8'hFF) frames_dropped <= frames_dropped + 8'd1;
        end
    end

    // Pose snapshot is taken in the cycle that decides to enter LATCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pose_pos_x   <= '0;
            pose_pos_y   <= '0;
            pose_pos_z   <= '0;
            pose_angle_x <= '0;
            pose_angle_y <= '0;
        end else if (state_nxt == LATCH && state != LATCH) begin
            pose_pos_x   <= p_pos_x;
            pose_pos_y   <= p_pos_y;
            pose_pos_z   <= p_pos_z;
            pose_angle_x <= p_angle_x;
            pose_angle_y <= p_angle_y;
        end
    end

    // Stage p1: map write port, one cycle behind the FIFO pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_vld_p1 <= pop;
            if (pop) begin
                wr_addr_p1 <= fifo_rdata[EDIT_W-1:BID_W];
                wr_data_p1 <= fifo_rdata[BID_W-1:0];
            end
        end
    end

`ifdef FRAME_SCHED_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        timeout_q;

    assign wd_hit  = (state == RENDER) && (wd_cnt == 32'(TIMEOUT_CYC - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == LATCH)       wd_cnt <= '0;
            else if (state == RENDER) wd_cnt <= wd_cnt + 32'd1;
            timeout_q <= wd_hit;
        end
    end
`else
    logic [31:0] wd_unused;

    assign wd_unused = 32'(TIMEOUT_CYC);
    assign wd_hit    = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sched.sv
// Directed bench for frame_sched at 4x2 resolution with a per-cycle reference model of
// frames, pose snapshots, dropped requests and the edit commit order.
module tb_frame_sched;

    localparam int DEPTH = 8;
    localparam int NPIX  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_req;
    logic [16:0] p_pos_x, p_pos_y, p_pos_z;
    logic [15:0] p_angle_x, p_angle_y;
    logic [16:0] pose_pos_x, pose_pos_y, pose_pos_z;
    logic [15:0] pose_angle_x, pose_angle_y;
    logic        start, px_valid, busy;
    logic        edit_valid, edit_ready;
    logic [14:0] edit_addr;
    logic [4:0]  edit_data;
    logic        write_en;
    logic [14:0] write_addr;
    logic [4:0]  write_data;
    logic [7:0]  frames_dropped;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    frame_sched #(
        .H_DISP      (4),
        .V_DISP      (2),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_req      (frame_req),
        .p_pos_x        (p_pos_x),
        .p_pos_y        (p_pos_y),
        .p_pos_z        (p_pos_z),
        .p_angle_x      (p_angle_x),
        .p_angle_y      (p_angle_y),
        .pose_pos_x     (pose_pos_x),
        .pose_pos_y     (pose_pos_y),
        .pose_pos_z     (pose_pos_z),
        .pose_angle_x   (pose_angle_x),
        .pose_angle_y   (pose_angle_y),
        .start          (start),
        .px_valid       (px_valid),
        .busy           (busy),
        .edit_valid     (edit_valid),
        .edit_ready     (edit_ready),
        .edit_addr      (edit_addr),
        .edit_data      (edit_data),
        .write_en       (write_en),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .frames_dropped (frames_dropped),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model state
    logic [19:0] q[$];
    logic [82:0] m_pose;
    logic [82:0] p_prev;
    int          accepted = 0;
    int          starts   = 0;
    int          m_drops  = 0;
    int          m_px     = 0;
    bit          m_active = 0;

    always @(negedge clk) begin
        logic [82:0] pose_now;
        bit          exp_busy;
        pose_now = {pose_pos_x, pose_pos_y, pose_pos_z, pose_angle_x, pose_angle_y};
        if (rst) begin
            chk("rst_start", start, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_write_en", write_en, 1'b0);
            chk("rst_write_bus", {write_addr, write_data}, 20'h0);
            chk("rst_edit_ready", edit_ready, 1'b1);
            chk("rst_dropped", frames_dropped, 8'd0);
            chk("rst_pose", pose_now, 83'h0);
            chk("rst_timeout", timeout, 1'b0);
            q.delete();
            accepted = 0; starts = 0; m_drops = 0; m_px = 0; m_active = 0;
            m_pose = '0;
        end else begin
            if (q.size() == 0) begin
                chk("spurious_write", write_en, 1'b0);
            end else if (write_en) begin
                chk("write_during_frame", busy, 1'b0);
                chk("write_order", {write_addr, write_data}, q[0]);
                void'(q.pop_front());
            end
            chk("edit_ready", edit_ready, q.size() < DEPTH);
            if (edit_valid && q.size() < DEPTH) q.push_back({edit_addr, edit_data});

            if (start) begin
                starts++;
                m_pose   = p_prev;
                m_active = 1;
                m_px     = 0;
                chk("busy_at_start", busy, 1'b1);
            end else begin
`ifdef FRAME_SCHED_TIMEOUT_EN
                if (timeout) m_active = 0;
`endif
                exp_busy = m_active && (m_px < NPIX);
                chk("busy", busy, exp_busy);
                if (m_active && m_px >= NPIX) m_active = 0;
                if (px_valid && m_active) m_px++;
            end
            chk("pose", pose_now, m_pose);
            chk("frames_dropped", frames_dropped, 8'(m_drops));
            if (frame_req) begin
                if (accepted - starts >= 1) begin
                    if (m_drops < 255) m_drops++;
                end else begin
                    accepted++;
                end
            end
`ifndef FRAME_SCHED_TIMEOUT_EN
            chk("timeout_off", timeout, 1'b0);
`endif
        end
        p_prev = {p_pos_x, p_pos_y, p_pos_z, p_angle_x, p_angle_y};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input logic [16:0] x, input logic [15:0] ax);
        p_pos_x   = x;
        p_angle_x = ax;
        p_pos_y   = x ^ 17'h0055A;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        p_pos_x   = ~x;
        chk("latch_start", start, 1'b1);
        chk("latch_pose_x", pose_pos_x, x);
        tick();
        chk("render_start_low", start, 1'b0);
        chk("render_busy", busy, 1'b1);
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) begin
            px_valid = 1'b1;
            tick();
        end
        px_valid = 1'b0;
    endtask

    task automatic push(input logic [14:0] a, input logic [4:0] d);
        edit_valid = 1'b1;
        edit_addr  = a;
        edit_data  = d;
        tick();
        edit_valid = 1'b0;
    endtask

    // Called in the first idle cycle after a frame ends.
    task automatic expect_commit(input logic [14:0] a0, input logic [4:0] d0, input int n);
        chk("commit_gap0", write_en, 1'b0);
        tick();
        chk("commit_gap1", write_en, 1'b0);
        tick();
        for (int j = 0; j < n; j++) begin
            chk("commit_en", write_en, 1'b1);
            chk("commit_addr", write_addr, a0 + 15'(j));
            chk("commit_data", write_data, d0 + 5'(j));
            tick();
        end
        chk("commit_done", write_en, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; frame_req = 1'b0; px_valid = 1'b0; edit_valid = 1'b0;
        edit_addr = '0; edit_data = '0;
        p_pos_x = 17'h00123; p_pos_y = 17'h00456; p_pos_z = 17'h00789;
        p_angle_x = 16'h1111; p_angle_y = 16'h2222;
        tick(); tick(); tick();
        chk("reset_edit_ready", edit_ready, 1'b1);
        chk("reset_pose_x", pose_pos_x, 17'h0);
        rst = 1'b0;

        // Normal frame: request at cycle 10
        for (int i = 0; i < 10; i++) tick();
        chk("idle_busy", busy, 1'b0);
        p_pos_z = 17'h1ABCD;
        begin_frame(17'h10800, 16'h4000);
        chk("pose_z_latched", pose_pos_z, 17'h1ABCD);
        pixels(7);
        chk("busy_before_last", busy, 1'b1);
        pixels(1);
        chk("frame_end_idle", busy, 1'b0);
        chk("pose_held", pose_pos_x, 17'h10800);

        // Deferred edits
        tick();
        begin_frame(17'h00200, 16'h0100);
        push(15'h0001, 5'd5);
        push(15'h0002, 5'd6);
        push(15'h0003, 5'd7);
        chk("no_write_in_render", write_en, 1'b0);
        pixels(NPIX);
        expect_commit(15'h0001, 5'd5, 3);

        // FIFO full
        tick();
        begin_frame(17'h00300, 16'h0200);
        for (int i = 0; i < 9; i++) begin
            chk("full_ready", edit_ready, (i < DEPTH) ? 1'b1 : 1'b0);
            edit_valid = 1'b1;
            edit_addr  = 15'h0100 + 15'(i);
            edit_data  = 5'd10 + 5'(i);
            tick();
        end
        edit_valid = 1'b0;
        chk("full_ready_held", edit_ready, 1'b0);
        pixels(NPIX);
        expect_commit(15'h0100, 5'd10, 8);
        chk("empty_ready", edit_ready, 1'b1);

        // Overrun: three requests in one frame
        tick();
        begin_frame(17'h00400, 16'h0300);
        for (int i = 0; i < 3; i++) begin
            frame_req = 1'b1;
            tick();
            frame_req = 1'b0;
            tick();
        end
        chk("overrun_dropped", frames_dropped, 8'd2);
        pixels(NPIX);
        chk("overrun_latch", start, 1'b1);
        tick();
        pixels(NPIX);
        chk("overrun_frame_end", busy, 1'b0);

        // Commit interrupted by a frame request after one write
        tick();
        begin_frame(17'h00500, 16'h0400);
        for (int i = 0; i < 4; i++) push(15'h0200 + 15'(i), 5'd20 + 5'(i));
        pixels(NPIX);
        tick();
        tick();
        chk("intr_write0", {write_en, write_addr, write_data}, {1'b1, 15'h0200, 5'd20});
        p_pos_x   = 17'h0ACE1;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        chk("intr_write1", {write_en, write_addr, write_data}, {1'b1, 15'h0201, 5'd21});
        chk("intr_no_start_yet", start, 1'b0);
        tick();
        chk("intr_latch", start, 1'b1);
        chk("intr_latch_no_write", write_en, 1'b0);
        chk("intr_pose", pose_pos_x, 17'h0ACE1);
        tick();
        pixels(NPIX);
        expect_commit(15'h0202, 5'd22, 2);
        chk("dropped_kept", frames_dropped, 8'd2);

        // Reset in the middle of a frame discards queued edits
        tick();
        begin_frame(17'h00600, 16'h0500);
        push(15'h0300, 5'd1);
        push(15'h0301, 5'd2);
        rst = 1'b1;
        tick();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_dropped", frames_dropped, 8'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_no_write", write_en, 1'b0);
            tick();
        end
        begin_frame(17'h00700, 16'h0600);
        pixels(NPIX);
        chk("post_rst_frame_end", busy, 1'b0);

`ifdef FRAME_SCHED_TIMEOUT_EN
        tick();
        begin_frame(17'h00800, 16'h0700);
        for (int k = 1; k < 50; k++) begin
            tick();
            chk("wd_waiting", {timeout, busy}, 2'b01);
        end
        tick();
        chk("wd_pulse", {timeout, busy}, 2'b10);
        tick();
        chk("wd_pulse_end", timeout, 1'b0);
`endif

        for (int i = 0; i < 4; i++) tick();
        chk("all_requests_served", starts, accepted);
        chk("all_edits_written", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
